tiny_bnn: RTL and testbench
===========================

// Module: tiny_bnn
// PURPOSE
//  Tiny two-layer binary neural network (8 inputs -> 8 hidden -> 8 outputs) for a
//  TinyTapeout tile. Each neuron applies XNOR to its inputs and weights, counts the
//  matching bits, and compares the count with a threshold.
//  All weights and thresholds load serially through a 192-bit parameter shift chain.
//  The 8-bit input vector arrives as two 4-bit nibbles.
//  Sits behind the tt_um_ei5baer_tiny_bnn pin wrapper, which maps ui_in/uo_out onto these ports.
// PARAMETERS
//  N      8    inputs per neuron = neurons per layer (fixed; RTL does not need to support other values)
//  TW     4    threshold width in bits
//  PLEN   192  parameter chain length = 2 * N * (N + TW)
// PORTS
//  clk        in   1  single clock; all state is rising-edge
//  rst        in   1  asynchronous, active-high reset
//  setup      in   1  1 = shift parameter chain; 0 = run mode
//  param_in   in   1  serial parameter bit, sampled while setup=1
//  x_bank_hi  in   1  nibble select: 0 writes x_reg[3:0], 1 writes x_reg[7:4]
//  x_nib      in   4  input nibble
//  y          out  8  registered network output, y[j] = output neuron j
// BEHAVIOUR
//  - Reset (async, rst=1): P=0, x_reg=0, y=0x00. Reset mid-load discards the partial chain.
//  - setup=1 at each rising edge:
//      P <= {P[190:0], param_in}  (MSB-first: the first bit sent ends in P[191] after 192 shifts)
//      x_reg and y hold.
//  - setup=0 at each rising edge, both in parallel:
//      x_reg[bank*4 +: 4] <= x_nib, where bank = x_bank_hi
//      y <= L2(L1(x_reg)), computed from the pre-edge x_reg
//  - Latency: a nibble written at edge k appears in y after edge k+1. y changes only at clock edges.
//  - Chain layout:
//      layer-1 neuron j = P[96 + 12j +: 12]; layer-2 neuron j = P[12j +: 12]
//      within a 12-bit field: [7:0] = weights w (w[i] pairs with input i), [11:8] = threshold T (unsigned)
//  - Neuron: out = (popcount(~(in ^ w)) >= T). The count is 0..8, held in 4 bits.
//      T = 0 always fires; T >= 9 never fires.
//  - L1 input = x_reg; L2 input = hidden vector h[7:0], h[j] = layer-1 neuron j.
//      The logic is purely combinational; only y is registered.
//  - More than 192 shifts: the oldest bits fall off P[191]; no error or flag.
//  - setup toggling: no handshake. Leaving setup on any edge returns to run mode with the current P.
// STRUCTURE
//  - Package tiny_bnn_pkg: localparams N, TW, PLEN, FIELD=N+TW, L1_BASE=N*FIELD,
//    plus a function for the neuron field offset.
//  - Sub-module bnn_neuron (in[7:0], w[7:0], t[3:0] -> fire), combinational.
//    Instantiated 16 times via generate.
//  - Top holds P, x_reg and the y register.
// TESTING
//  1. rst pulse -> y=0x00; with setup=0, any x -> y=0xFF one edge later (all T=0 fire).
//  2. Shift 192 ones, then x=0xA5 in run mode.
//     -> every T=15 never fires -> y=0x00.
//  3. Load every neuron w=0xFF; layer-1 T=4, layer-2 T=8.
//     x=0x0F -> y=0xFF; x=0x07 -> y=0x00.
//  4. Load layer-1 and layer-2 neuron j with w=1<<j, T=8.
//     x=0x01 -> y=0x01; x=0x80 -> y=0x80; x=0x03 -> y=0x00.
//  5. Nibble timing: bank0=0xF at edge k, bank1=0x0 at edge k+1, using the case-3 parameters.
//     -> y=0xFF after edge k+1.
//     With setup=1, x_nib changes and y holds.
//  6. Assert rst after 100 shift edges -> y=0x00 and P=0.
//     The subsequent run gives y=0xFF, as in case 1.

Source files
------------

// File: rtl/tiny_bnn_pkg.sv
// Shared sizes and parameter-chain layout helpers for the tiny binary neural network.
package tiny_bnn_pkg;
  localparam int N       = 8;
  localparam int TW      = 4;
  localparam int FIELD   = N + TW;
  localparam int PLEN    = 2 * N * FIELD;
  localparam int L1_BASE = N * FIELD;

  // Bit offset of neuron j's 12-bit field inside the chain (layer 1 sits above layer 2).
  function automatic int field_lsb(input bit is_l1, input int j);
    return (is_l1 ? L1_BASE : 0) + j * FIELD;
  endfunction
endpackage

// File: rtl/tiny_bnn_if.sv
// Pin-level bundle between the TinyTapeout wrapper and the network core.
interface tiny_bnn_if;
  logic       setup;
  logic       param_in;
  logic       x_bank_hi;
  logic [3:0] x_nib;
  logic [7:0] y;

  modport master (output setup, output param_in, output x_bank_hi, output x_nib, input y);
  modport slave  (input setup, input param_in, input x_bank_hi, input x_nib, output y);
endinterface

// File: rtl/tiny_bnn_neuron.sv
// Binary neuron: fires when the number of input bits matching the weights reaches the threshold.
module bnn_neuron
  import tiny_bnn_pkg::*;
(
  input  logic [N-1:0]  i_in,
  input  logic [N-1:0]  i_w,
  input  logic [TW-1:0] i_t,
  output logic          o_fire
);
  logic [N-1:0]  w_match;
  logic [TW-1:0] w_cnt;

  assign w_match = ~(i_in ^ i_w);

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) w_cnt = w_cnt + {{(TW-1){1'b0}}, w_match[i]};
  end

  assign o_fire = (w_cnt >= i_t);
endmodule

// File: rtl/tiny_bnn.sv
// Two-layer 8x8x8 binary network: serial parameter chain, nibble-loaded input, registered output.
module tiny_bnn
  import tiny_bnn_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  tiny_bnn_if.slave bus
);
  logic [PLEN-1:0] r_p;
  logic [N-1:0]    r_x;
  logic [N-1:0]    r_y;
  logic [N-1:0]    w_h;
  logic [N-1:0]    w_o;

  for (genvar j = 0; j < N; j++) begin : g_neuron
    localparam int L1_LSB = field_lsb(1'b1, j);
    localparam int L2_LSB = field_lsb(1'b0, j);

    bnn_neuron u_l1 (
      .i_in   (r_x),
      .i_w    (r_p[L1_LSB +: N]),
      .i_t    (r_p[L1_LSB + N +: TW]),
      .o_fire (w_h[j])
    );

    bnn_neuron u_l2 (
      .i_in   (w_h),
      .i_w    (r_p[L2_LSB +: N]),
      .i_t    (r_p[L2_LSB + N +: TW]),
      .o_fire (w_o[j])
    );
  end

  // Output samples the network from the pre-edge input register, so a nibble shows up one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
      r_x <= '0;
      r_y <= '0;
    end else if (bus.setup) begin
      r_p <= {r_p[PLEN-2:0], bus.param_in};
    end else begin
      if (bus.x_bank_hi) r_x[7:4] <= bus.x_nib;
      else               r_x[3:0] <= bus.x_nib;
      r_y <= w_o;
    end
  end

  assign bus.y = r_y;
endmodule

// File: tb/tb_tiny_bnn.sv
// Self-checking bench for tiny_bnn against a popcount-based reference of the network.
module tb_tiny_bnn;
  logic clk = 1'b0;
  logic rst = 1'b1;
  tiny_bnn_if bus ();

  tiny_bnn dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [191:0] mp;
  logic [7:0]   mx;
  logic [7:0]   my;

  function automatic logic [7:0] ref_layer(input logic [191:0] p, input int base, input logic [7:0] v);
    logic [7:0]  r;
    logic [11:0] f;
    for (int j = 0; j < 8; j++) begin
      f = p[base + 12*j +: 12];
      r[j] = ($countones(~(v ^ f[7:0])) >= int'(f[11:8]));
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_net(input logic [191:0] p, input logic [7:0] x);
    return ref_layer(p, 0, ref_layer(p, 96, x));
  endfunction

  function automatic logic [191:0] uniform_p(input logic [7:0] w1, input logic [3:0] t1,
                                             input logic [7:0] w2, input logic [3:0] t2);
    logic [191:0] p;
    for (int j = 0; j < 8; j++) begin
      p[96 + 12*j +: 12] = {t1, w1};
      p[12*j +: 12]      = {t2, w2};
    end
    return p;
  endfunction

  task automatic step(input logic s, input logic pin, input logic bank, input logic [3:0] nib);
    bus.setup     = s;
    bus.param_in  = pin;
    bus.x_bank_hi = bank;
    bus.x_nib     = nib;
    @(posedge clk);
    if (s) mp = {mp[190:0], pin};
    else begin
      my = ref_net(mp, mx);
      if (bank) mx[7:4] = nib;
      else      mx[3:0] = nib;
    end
    #1;
  endtask

  task automatic load_chain(input logic [191:0] v);
    for (int i = 191; i >= 0; i--) step(1'b1, v[i], 1'($urandom), 4'($urandom));
  endtask

  // Two edges write x, a third edge registers the network result for it.
  task automatic apply_x(input logic [7:0] x);
    step(1'b0, 1'b0, 1'b0, x[3:0]);
    step(1'b0, 1'b0, 1'b1, x[7:4]);
    step(1'b0, 1'b0, 1'b0, x[3:0]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    mp = '0; mx = '0; my = '0;
    n_total++;
    if (bus.y !== 8'h00) $display("FAIL reset_y got=%h exp=00", bus.y); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_default_fire;
    step(1'b0, 1'b0, 1'b0, 4'h3);
    n_total++;
    if (bus.y !== 8'hFF) $display("FAIL default_fire got=%h exp=FF", bus.y); else n_pass++;
  endtask

  task automatic test_all_ones;
    load_chain({192{1'b1}});
    apply_x(8'hA5);
    n_total++;
    if (bus.y !== 8'h00) $display("FAIL t15_never got=%h exp=00", bus.y); else n_pass++;
  endtask

  task automatic test_threshold;
    load_chain(uniform_p(8'hFF, 4'd4, 8'hFF, 4'd8));
    apply_x(8'h0F);
    n_total++;
    if (bus.y !== 8'hFF) $display("FAIL thr_0F got=%h exp=FF", bus.y); else n_pass++;
    apply_x(8'h07);
    n_total++;
    if (bus.y !== 8'h00) $display("FAIL thr_07 got=%h exp=00", bus.y); else n_pass++;
  endtask

  task automatic test_onehot;
    logic [191:0] p;
    logic [7:0]   xs [3]  = '{8'h01, 8'h80, 8'h03};
    logic [7:0]   exp [3] = '{8'h01, 8'h80, 8'h00};
    for (int j = 0; j < 8; j++) begin
      p[96 + 12*j +: 12] = {4'd8, 8'(1 << j)};
      p[12*j +: 12]      = {4'd8, 8'(1 << j)};
    end
    load_chain(p);
    for (int k = 0; k < 3; k++) begin
      apply_x(xs[k]);
      n_total++;
      if (bus.y !== exp[k]) $display("FAIL onehot_%0d got=%h exp=%h", k, bus.y, exp[k]); else n_pass++;
    end
  endtask

  task automatic test_nibble_timing;
    logic [7:0] y_hold;
    load_chain(uniform_p(8'hFF, 4'd4, 8'hFF, 4'd8));
    apply_x(8'h00);
    n_total++;
    if (bus.y !== 8'h00) $display("FAIL nib_pre got=%h exp=00", bus.y); else n_pass++;
    step(1'b0, 1'b0, 1'b0, 4'hF);
    n_total++;
    if (bus.y !== 8'h00) $display("FAIL nib_edge_k got=%h exp=00", bus.y); else n_pass++;
    step(1'b0, 1'b0, 1'b1, 4'h0);
    n_total++;
    if (bus.y !== 8'hFF) $display("FAIL nib_edge_k1 got=%h exp=FF", bus.y); else n_pass++;
    y_hold = my;
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom));
    n_total++;
    if (bus.y !== y_hold) $display("FAIL setup_hold got=%h exp=%h", bus.y, y_hold); else n_pass++;
    step(1'b0, 1'b0, 1'b0, 4'h5);
    n_total++;
    if (bus.y !== my) $display("FAIL shifted_run got=%h exp=%h", bus.y, my); else n_pass++;
  endtask

  task automatic test_reset_midload;
    for (int i = 0; i < 100; i++) step(1'b1, 1'($urandom), 1'b0, 4'h0);
    rst = 1'b1;
    #2;
    mp = '0; mx = '0; my = '0;
    n_total++;
    if (bus.y !== 8'h00) $display("FAIL midload_rst got=%h exp=00", bus.y); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'($urandom));
    n_total++;
    if (bus.y !== 8'hFF) $display("FAIL midload_run got=%h exp=FF", bus.y); else n_pass++;
  endtask

  task automatic test_random;
    logic [191:0] p;
    int errs;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 16; j++) p[12*j +: 12] = {4'($urandom_range(2, 7)), 8'($urandom)};
      load_chain(p);
      errs = 0;
      for (int c = 0; c < 80; c++) begin
        step(1'b0, 1'b0, 1'($urandom), 4'($urandom));
        n_total++;
        if (bus.y !== my) begin
          errs++;
          if (errs <= 4) $display("FAIL random_r%0d_c%0d got=%h exp=%h", r, c, bus.y, my);
        end else n_pass++;
      end
    end
  endtask

  initial begin
    bus.setup = 1'b0; bus.param_in = 1'b0; bus.x_bank_hi = 1'b0; bus.x_nib = 4'h0;
    mp = '0; mx = '0; my = '0;
    test_reset();
    test_default_fire();
    test_all_ones();
    test_threshold();
    test_onehot();
    test_nibble_timing();
    test_reset_midload();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
